sdram_frame_reader: RTL and testbench

//  Avalon-MM read master for the SDRAM controller s1 slave: fetches a contiguous block of
//  16-bit words (one SLM frame or part of one) starting at a word address and streams them
//  out on a valid/ready pixel interface. It sits between the reader_system SDRAM port and the
//  SLM display pipeline. It issues pipelined reads, limited by credit so returned data never overflows.

---
 rtl/sdram_reader_pkg.sv | 21 ++
 rtl/sdram_frame_reader_if.sv | 49 ++++
 rtl/sdram_rd_fifo.sv | 77 +++++++
 rtl/sdram_frame_reader.sv | 155 +++++++++++++++
 tb/tb_sdram_frame_reader.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_reader_pkg
// Description : Shared definitions for the SDRAM reader/writer blocks: state
//               encoding of the frame reader FSM and the default SDRAM
//               word-address / data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_reader_pkg;

    localparam int c_addr_w = 25;
    localparam int c_data_w = 16;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_issue = 2'd1;
    localparam state_t c_st_drain = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sdram_frame_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : sdram_frame_reader_if
// Description : Avalon-MM bus towards the SDRAM controller s1 slave.
//               master : read master side (address/control out, data in)
//               slave  : SDRAM controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface sdram_frame_reader_if #(
    parameter int ADDR_W = sdram_reader_pkg::c_addr_w,
    parameter int DATA_W = sdram_reader_pkg::c_data_w
);

    logic [ADDR_W-1:0] sdram_controller_0_s1_address;
    logic [1:0]        sdram_controller_0_s1_byteenable_n;
    logic              sdram_controller_0_s1_chipselect;
    logic [DATA_W-1:0] sdram_controller_0_s1_writedata;
    logic              sdram_controller_0_s1_read_n;
    logic              sdram_controller_0_s1_write_n;
    logic [DATA_W-1:0] sdram_controller_0_s1_readdata;
    logic              sdram_controller_0_s1_readdatavalid;
    logic              sdram_controller_0_s1_waitrequest;

    modport master (
        output sdram_controller_0_s1_address,
        output sdram_controller_0_s1_byteenable_n,
        output sdram_controller_0_s1_chipselect,
        output sdram_controller_0_s1_writedata,
        output sdram_controller_0_s1_read_n,
        output sdram_controller_0_s1_write_n,
        input  sdram_controller_0_s1_readdata,
        input  sdram_controller_0_s1_readdatavalid,
        input  sdram_controller_0_s1_waitrequest
    );

    modport slave (
        input  sdram_controller_0_s1_address,
        input  sdram_controller_0_s1_byteenable_n,
        input  sdram_controller_0_s1_chipselect,
        input  sdram_controller_0_s1_writedata,
        input  sdram_controller_0_s1_read_n,
        input  sdram_controller_0_s1_write_n,
        output sdram_controller_0_s1_readdata,
        output sdram_controller_0_s1_readdatavalid,
        output sdram_controller_0_s1_waitrequest
    );

endinterface
`default_nettype wire

// File: rtl/sdram_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rd_fifo
// Description : Synchronous first-word-fall-through FIFO for returned SDRAM
//               read data. o_dout always shows the head word; o_count is the
//               current fill level. Push and pop in the same cycle are legal,
//               also when the FIFO is full.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   i_push/i_din : write strobe and data
//   i_pop      : consume head word (ignored when empty)
//   o_dout, o_empty, o_count : head word, empty flag, fill level
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_rd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire logic [WIDTH-1:0]       i_din,
    input  wire logic                   i_pop,
    output logic      [WIDTH-1:0]       o_dout,
    output logic                        o_empty,
    output logic      [$clog2(DEPTH):0] o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    assign w_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
        end
    end

    // Upstream credit accounting must make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_push && w_full && !w_pop));
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : sdram_frame_reader
// Description : Avalon-MM read master that fetches word_count contiguous
//               16-bit words from SDRAM starting at base_addr and streams
//               them out on a valid/ready pixel interface. Reads are
//               pipelined and throttled by credit so returned data always
//               fits in the return FIFO.
//   clk_clk, reset_reset          : clock, synchronous active-high reset
//   start, base_addr, word_count  : transfer request (sampled in IDLE)
//   busy, done                    : transfer status, done is a 1-cycle pulse
//   s1                            : Avalon-MM master towards SDRAM s1
//   pix_data/valid/last, pix_ready: output pixel stream
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_frame_reader
    import sdram_reader_pkg::*;
#(
    parameter int ADDR_W     = c_addr_w,
    parameter int DATA_W     = c_data_w,
    parameter int FIFO_DEPTH = 16
) (
    input  wire logic              clk_clk,
    input  wire logic              reset_reset,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [ADDR_W-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    sdram_frame_reader_if.master   s1,
    output logic      [DATA_W-1:0] pix_data,
    output logic                   pix_valid,
    output logic                   pix_last,
    input  wire logic              pix_ready
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam int c_sum_w = c_cnt_w + 1;

    state_t              r_state;
    logic                r_read_n;
    logic                r_zero_done;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_issue_left;
    logic [ADDR_W-1:0]   r_len;
    logic [ADDR_W-1:0]   r_pop_cnt;
    logic [c_cnt_w-1:0]  r_inflight;

    logic                w_accept;
    logic                w_rdv;
    logic                w_pop;
    logic                w_empty;
    logic [c_cnt_w-1:0]  w_fifo_count;
    logic [c_sum_w-1:0]  w_credit_sum;
    logic                w_credit_ok;

    assign w_accept = (r_state == c_st_issue) && !r_read_n && !s1.sdram_controller_0_s1_waitrequest;
    // Responses seen in IDLE belong to reads issued before a reset.
    assign w_rdv    = s1.sdram_controller_0_s1_readdatavalid && (r_state != c_st_idle);
    assign w_pop    = pix_valid && pix_ready;

    // Occupancy as it will stand next cycle, when a newly presented read
    // would first be visible to the slave.
    assign w_credit_sum = c_sum_w'(r_inflight) + c_sum_w'(w_fifo_count)
                        + c_sum_w'(w_accept) - c_sum_w'(w_pop);
    assign w_credit_ok  = (w_credit_sum < c_sum_w'(FIFO_DEPTH));

    sdram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .i_push  (w_rdv),
        .i_din   (s1.sdram_controller_0_s1_readdata),
        .i_pop   (w_pop),
        .o_dout  (pix_data),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    assign pix_valid = !w_empty;
    assign pix_last  = pix_valid && (r_pop_cnt == r_len - ADDR_W'(1));
    assign busy      = (r_state != c_st_idle);
    assign done      = r_zero_done || ((r_state == c_st_drain) && w_pop && pix_last);

    assign s1.sdram_controller_0_s1_address      = r_addr;
    assign s1.sdram_controller_0_s1_read_n       = r_read_n;
    assign s1.sdram_controller_0_s1_chipselect   = !r_read_n;
    assign s1.sdram_controller_0_s1_byteenable_n = 2'b00;
    assign s1.sdram_controller_0_s1_writedata    = '0;
    assign s1.sdram_controller_0_s1_write_n      = 1'b1;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state      <= c_st_idle;
            r_read_n     <= 1'b1;
            r_zero_done  <= 1'b0;
            r_addr       <= '0;
            r_issue_left <= '0;
            r_len        <= '0;
            r_pop_cnt    <= '0;
            r_inflight   <= '0;
        end else begin
            r_zero_done <= 1'b0;
            if (r_state != c_st_idle) begin
                r_inflight <= r_inflight + c_cnt_w'(w_accept) - c_cnt_w'(w_rdv);
            end
            if (w_pop) begin
                r_pop_cnt <= r_pop_cnt + ADDR_W'(1);
            end
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        if (word_count == '0) begin
                            r_zero_done <= 1'b1;
                        end else begin
                            r_state      <= c_st_issue;
                            r_addr       <= base_addr;
                            r_len        <= word_count;
                            r_issue_left <= word_count;
                            r_pop_cnt    <= '0;
                            r_read_n     <= 1'b0;
                        end
                    end
                end
                c_st_issue: begin
                    if (w_accept) begin
                        r_addr       <= r_addr + ADDR_W'(1);
                        r_issue_left <= r_issue_left - ADDR_W'(1);
                    end
                    if (w_accept && (r_issue_left == ADDR_W'(1))) begin
                        r_read_n <= 1'b1;
                        r_state  <= c_st_drain;
                    end else if (!r_read_n && !w_accept) begin
                        // Stalled request must stay on the bus untouched.
                        r_read_n <= r_read_n;
                    end else begin
                        r_read_n <= !w_credit_ok;
                    end
                end
                c_st_drain: begin
                    if (w_pop && pix_last) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_frame_reader
// Description : Directed self-checking bench for sdram_frame_reader with a
//               small SDRAM slave model (2-cycle read latency, programmable
//               waitrequest stall) and a stream monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_frame_reader;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        start = 1'b0;
    logic [24:0] base_addr = '0;
    logic [24:0] word_count = '0;
    logic        busy;
    logic        done;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_last;
    logic        pix_ready = 1'b1;

    sdram_frame_reader_if #(.ADDR_W(25), .DATA_W(16)) s1_bus ();

    sdram_frame_reader #(
        .ADDR_W     (25),
        .DATA_W     (16),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .busy        (busy),
        .done        (done),
        .s1          (s1_bus),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_last    (pix_last),
        .pix_ready   (pix_ready)
    );

    always #5 clk_clk = ~clk_clk;

    // Slave-side drive and bus observation
    logic        waitreq = 1'b0;
    logic        rdv = 1'b0;
    logic [15:0] rdata = '0;
    logic [24:0] bus_addr;
    logic        bus_read_n;
    logic        bus_cs;
    logic        bus_write_n;
    logic [1:0]  bus_be_n;

    assign s1_bus.sdram_controller_0_s1_waitrequest   = waitreq;
    assign s1_bus.sdram_controller_0_s1_readdatavalid = rdv;
    assign s1_bus.sdram_controller_0_s1_readdata      = rdata;
    assign bus_addr    = s1_bus.sdram_controller_0_s1_address;
    assign bus_read_n  = s1_bus.sdram_controller_0_s1_read_n;
    assign bus_cs      = s1_bus.sdram_controller_0_s1_chipselect;
    assign bus_write_n = s1_bus.sdram_controller_0_s1_write_n;
    assign bus_be_n    = s1_bus.sdram_controller_0_s1_byteenable_n;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [24:0] exp_base = '0;
    int exp_len = 0;
    int acc_idx = 0;
    int pop_idx = 0;
    int done_cnt = 0;
    int start_cyc = 0;
    int first_acc_cyc = -1;
    int last_acc_cyc = -1;
    int first_rdv_cyc = -1;
    int first_valid_cyc = -1;

    int          stall_left = 0;
    logic [24:0] stall_addr = '0;
    bit          prev_stall = 1'b0;
    logic [24:0] prev_stall_addr = '0;

    bit          p0_v = 1'b0;
    bit          p1_v = 1'b0;
    logic [24:0] p0_a = '0;
    logic [24:0] p1_a = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [24:0] a);
        return a[15:0] ^ {a[24:17], 8'h00} ^ 16'h3C5A;
    endfunction

    // Everything sampled mid-cycle; slave inputs change here, stimulus
    // changes just after the rising edge.
    always @(negedge clk_clk) begin
        logic [24:0] exp_a;
        logic [24:0] new_a;
        bit          new_v;
        cyc++;
        new_v = 1'b0;
        new_a = '0;
        if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pix_valid && pix_ready) begin
            exp_a = exp_base + 25'(pop_idx);
            check_eq("pix_data", 32'(pix_data), 32'(mem_word(exp_a)));
            check_eq("pix_last", 32'(pix_last), 32'(pop_idx == exp_len - 1));
            check_eq("done_on_last", 32'(done), 32'(pop_idx == exp_len - 1));
            pop_idx++;
        end
        if (done) done_cnt++;

        if (prev_stall) begin
            check_eq("hold_read_n", 32'(bus_read_n), 32'd0);
            check_eq("hold_addr", 32'(bus_addr), 32'(prev_stall_addr));
        end
        prev_stall = 1'b0;
        waitreq = 1'b0;
        if (!bus_read_n) begin
            if (stall_left > 0 && bus_addr == stall_addr) begin
                waitreq = 1'b1;
                stall_left--;
                prev_stall = 1'b1;
                prev_stall_addr = bus_addr;
            end else begin
                exp_a = exp_base + 25'(acc_idx);
                check_eq("rd_addr", 32'(bus_addr), 32'(exp_a));
                check_eq("chipselect", 32'(bus_cs), 32'd1);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                acc_idx++;
                new_v = 1'b1;
                new_a = bus_addr;
            end
        end

        // Two-stage return pipe: data comes back two edges after acceptance.
        rdv   = p1_v;
        rdata = p1_v ? mem_word(p1_a) : 16'h0000;
        if (p1_v && first_rdv_cyc < 0) first_rdv_cyc = cyc;
        p1_v = p0_v;
        p1_a = p0_a;
        p0_v = new_v;
        p0_a = new_a;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic begin_xfer(input logic [24:0] base, input int len);
        exp_base        = base;
        exp_len         = len;
        acc_idx         = 0;
        pop_idx         = 0;
        done_cnt        = 0;
        first_acc_cyc   = -1;
        last_acc_cyc    = -1;
        first_rdv_cyc   = -1;
        first_valid_cyc = -1;
        start_cyc       = cyc;
        start           = 1'b1;
        base_addr       = base;
        word_count      = 25'(len);
        idle(1);
        start           = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc && done_cnt == 0; i++) begin
            idle(1);
        end
    endtask

    task automatic check_xfer(input string tag, input int len);
        check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check_eq({tag, "_reads"}, 32'(acc_idx), 32'(len));
        check_eq({tag, "_words"}, 32'(pop_idx), 32'(len));
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check_eq("rst_read_n", 32'(bus_read_n), 32'd1);
        check_eq("rst_chipselect", 32'(bus_cs), 32'd0);
        check_eq("rst_address", 32'(bus_addr), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_pix_valid", 32'(pix_valid), 32'd0);
        check_eq("rst_pix_last", 32'(pix_last), 32'd0);
        check_eq("tie_write_n", 32'(bus_write_n), 32'd1);
        check_eq("tie_byteenable_n", 32'(bus_be_n), 32'd0);
        reset_reset = 1'b0;
        idle(2);

        // T1: plain 4-word burst
        begin_xfer(25'h100, 4);
        wait_done(40);
        check_xfer("t1", 4);
        check_eq("t1_first_read_lat", 32'(first_acc_cyc - start_cyc), 32'd2);
        check_eq("t1_back_to_back", 32'(last_acc_cyc - first_acc_cyc), 32'd3);
        check_eq("t1_valid_lat", 32'(first_valid_cyc - first_rdv_cyc), 32'd1);
        idle(4);

        // T2: three stall cycles on the second read
        stall_addr = 25'h101;
        stall_left = 3;
        begin_xfer(25'h100, 4);
        wait_done(40);
        check_xfer("t2", 4);
        check_eq("t2_stall_used", 32'(stall_left), 32'd0);
        check_eq("t2_accept_span", 32'(last_acc_cyc - first_acc_cyc), 32'd6);
        idle(4);

        // T3: blocked sink, credit limit, then release
        pix_ready = 1'b0;
        begin_xfer(25'h800, 40);
        idle(60);
        check_eq("t3_credit_reads", 32'(acc_idx), 32'd16);
        check_eq("t3_read_n_high", 32'(bus_read_n), 32'd1);
        check_eq("t3_pix_valid", 32'(pix_valid), 32'd1);
        check_eq("t3_busy", 32'(busy), 32'd1);
        pix_ready = 1'b1;
        wait_done(200);
        check_xfer("t3", 40);
        idle(4);

        // T4: address wrap at the top of the address space
        begin_xfer(25'h1FFFFFE, 4);
        wait_done(40);
        check_xfer("t4", 4);
        idle(4);

        // T5: zero-length request, then a start while busy
        done_cnt   = 0;
        acc_idx    = 0;
        start      = 1'b1;
        base_addr  = 25'h0;
        word_count = 25'h0;
        idle(1);
        start = 1'b0;
        check_eq("t5_zero_done", 32'(done), 32'd1);
        check_eq("t5_zero_busy", 32'(busy), 32'd0);
        idle(1);
        check_eq("t5_zero_done_pulse", 32'(done), 32'd0);
        idle(4);
        check_eq("t5_zero_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("t5_zero_no_reads", 32'(acc_idx), 32'd0);
        begin_xfer(25'h400, 4);
        idle(1);
        start      = 1'b1;
        base_addr  = 25'h500;
        word_count = 25'd2;
        idle(1);
        start = 1'b0;
        wait_done(40);
        check_xfer("t5", 4);
        idle(6);
        check_eq("t5_no_restart_done", 32'(done_cnt), 32'd1);
        check_eq("t5_no_restart_reads", 32'(acc_idx), 32'd4);

        // T6: reset mid-transfer with reads outstanding
        begin_xfer(25'h200, 40);
        idle(5);
        reset_reset = 1'b1;
        idle(1);
        reset_reset = 1'b0;
        check_eq("t6_read_n", 32'(bus_read_n), 32'd1);
        check_eq("t6_pix_valid", 32'(pix_valid), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        done_cnt = 0;
        idle(6);
        check_eq("t6_late_dropped", 32'(pix_valid), 32'd0);
        check_eq("t6_no_done", 32'(done_cnt), 32'd0);
        begin_xfer(25'h300, 3);
        wait_done(40);
        check_xfer("t6", 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
